// File: rtl/fifo_credit_drain_pkg.sv
// Shared widths and FSM encoding for the RAMFIFO read-side credit drain.
// The FIFO controller imports the same defaults so both sides agree on flit width.
package fifo_credit_drain_pkg;

    localparam int FLIT_W       = 36;
    localparam int CREDITS_DEF  = 4;
    localparam int CREDIT_W_DEF = 3;
    localparam int STALL_W_DEF  = 16;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } drain_state_e;

endpackage

// File: rtl/fifo_credit_drain_if.sv
// FIFO-side and link-side handshake bundle for the credit drain.
// master is the drain itself; slave is the FIFO/link environment around it.
interface fifo_credit_drain_if
    import fifo_credit_drain_pkg::*;
#(
    parameter int WIDTH = FLIT_W
);

    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_read;
    logic             credit_in;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  credit_in,
        output fifo_read,
        output out_valid,
        output out_data
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output credit_in,
        input  fifo_read,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/fifo_credit_drain_credit_counter.sv
// Saturating credit counter: resets full, counts down on dec, up on inc.
// A return while already full is latched in a sticky err bit.
module fifo_credit_drain_credit_counter #(
    parameter int CREDITS  = 4,
    parameter int CREDIT_W = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                inc,
    input  logic                dec,
    output logic [CREDIT_W-1:0] count,
    output logic [CREDIT_W-1:0] count_nxt,
    output logic                zero,
    output logic                err
);

    localparam logic [CREDIT_W-1:0] MAX = CREDIT_W'(CREDITS);

    logic full;
    logic err_nxt;

    assign zero = (count == '0);
    assign full = (count == MAX);

    // Simultaneous inc and dec cancel, so the count holds.
    always_comb begin
        count_nxt = count;
        err_nxt   = err;
        if (enable) begin
            if (inc && !dec) begin
                if (full) err_nxt = 1'b1;
                else      count_nxt = count + CREDIT_W'(1);
            end else if (dec && !inc && !zero) begin
                count_nxt = count - CREDIT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= MAX;
            err   <= 1'b0;
        end else begin
            count <= count_nxt;
            err   <= err_nxt;
        end
    end

endmodule

// File: rtl/fifo_credit_drain.sv
// Pops the RAMFIFO head whenever the link has credit and forwards it as a
// registered one-cycle flit; tracks stall state and stall cycles.
module fifo_credit_drain
    import fifo_credit_drain_pkg::*;
#(
    parameter int WIDTH    = FLIT_W,
    parameter int CREDITS  = CREDITS_DEF,
    parameter int CREDIT_W = CREDIT_W_DEF,
    parameter int STALL_W  = STALL_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    fifo_credit_drain_if.master link,
    output logic [CREDIT_W-1:0] credits,
    output logic                state_stalled,
    output logic [STALL_W-1:0]  stall_count,
    output logic                credit_err
);

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + STALL_W'(1);
    endfunction

    drain_state_e          state_q;
    drain_state_e          state_d;
    logic                  send;
    logic                  cred_zero;
    logic [CREDIT_W-1:0]   cred_nxt;
    logic                  vld_p1;
    logic [WIDTH-1:0]      data_p1;

    // Registered credits only: credit_in never reaches fifo_read combinationally.
    assign send           = enable && !link.fifo_empty && !cred_zero;
    assign link.fifo_read = send;

    fifo_credit_drain_credit_counter #(
        .CREDITS  (CREDITS),
        .CREDIT_W (CREDIT_W)
    ) u_credit_counter (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .inc       (link.credit_in),
        .dec       (send),
        .count     (credits),
        .count_nxt (cred_nxt),
        .zero      (cred_zero),
        .err       (credit_err)
    );

    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                RUN:     if (cred_nxt == '0 && !link.fifo_empty) state_d = STALL;
                STALL:   if (cred_nxt != '0 || link.fifo_empty)  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            stall_count <= '0;
        end else if (enable) begin
            state_q <= state_d;
            if (!link.fifo_empty && cred_zero) stall_count <= sat_inc(stall_count);
        end
    end

    assign state_stalled = (state_q == STALL);

    // p0 -> p1: flit register; data holds when nothing is sent.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (enable) begin
            vld_p1 <= send;
            if (send) data_p1 <= link.fifo_dout;
        end
    end

    assign link.out_valid = vld_p1;
    assign link.out_data  = data_p1;

endmodule

// File: tb/tb_fifo_credit_drain.sv
// Directed bench for fifo_credit_drain: per-cycle vector table plus hand sequences
// for reset mid-send, enable freeze and stall-counter saturation.
module tb_fifo_credit_drain;

    localparam int W  = 36;
    localparam int CW = 3;
    localparam int SW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic [CW-1:0] credits;
    logic          state_stalled;
    logic [SW-1:0] stall_count;
    logic          credit_err;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_credit_drain_if #(.WIDTH(W)) dif ();

    fifo_credit_drain #(
        .WIDTH(W), .CREDITS(4), .CREDIT_W(CW), .STALL_W(SW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .link          (dif),
        .credits       (credits),
        .state_stalled (state_stalled),
        .stall_count   (stall_count),
        .credit_err    (credit_err)
    );

    always #5 clock = ~clock;

    // Behavioural FIFO: head presented combinationally, popped on fifo_read.
    logic [W-1:0] mem [0:255];
    logic [7:0]   rd_ptr = '0;
    logic [7:0]   wr_ptr = '0;

    assign dif.fifo_empty = (rd_ptr == wr_ptr);
    assign dif.fifo_dout  = mem[rd_ptr];

    always @(posedge clock) if (dif.fifo_read) rd_ptr <= rd_ptr + 8'd1;

    typedef struct {
        logic          en;
        logic          cin;
        logic          exp_read;
        logic          exp_valid;
        logic [W-1:0]  exp_data;
        logic [CW-1:0] exp_cred;
        logic          exp_stalled;
        logic [SW-1:0] exp_scnt;
        logic          exp_err;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic en, input logic cin, input logic rd,
                                input logic vl, input logic [W-1:0] d, input logic [CW-1:0] cr,
                                input logic st, input logic [SW-1:0] sc, input logic er);
        vec_t v;
        v.en = en; v.cin = cin; v.exp_read = rd; v.exp_valid = vl; v.exp_data = d;
        v.exp_cred = cr; v.exp_stalled = st; v.exp_scnt = sc; v.exp_err = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_regs(input string nm, input logic vl, input logic [W-1:0] d,
                            input logic [CW-1:0] cr, input logic st, input logic [SW-1:0] sc,
                            input logic er);
        chk({nm, ".out_valid"},     64'(dif.out_valid),     64'(vl));
        chk({nm, ".out_data"},      64'(dif.out_data),      64'(d));
        chk({nm, ".credits"},       64'(credits),           64'(cr));
        chk({nm, ".state_stalled"}, 64'(state_stalled),     64'(st));
        chk({nm, ".stall_count"},   64'(stall_count),       64'(sc));
        chk({nm, ".credit_err"},    64'(credit_err),        64'(er));
    endtask

    task automatic push(input logic [W-1:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        enable = 1'b0;
        dif.credit_in = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        wr_ptr = rd_ptr;
    endtask

    // Drive one enabled/disabled cycle, check the pop request, then the registered outputs.
    task automatic step(input logic en, input logic cin, input logic exp_read);
        @(negedge clock);
        enable = en;
        dif.credit_in = cin;
        #1;
        chk("fifo_read", 64'(dif.fifo_read), 64'(exp_read));
        @(posedge clock);
        #1;
    endtask

    initial begin
        dif.credit_in = 1'b0;

        // Reset state
        @(posedge clock);
        #1;
        chk_regs("reset", 1'b0, '0, 3'd4, 1'b0, 4'd0, 1'b0);
        do_reset();

        // Burst of six, stall, single credit, simultaneous send+credit, credit overflow
        tbl[0]  = mk(1, 0, 1, 1, 36'h1, 3'd3, 0, 4'd0, 0);
        tbl[1]  = mk(1, 0, 1, 1, 36'h2, 3'd2, 0, 4'd0, 0);
        tbl[2]  = mk(1, 0, 1, 1, 36'h3, 3'd1, 0, 4'd0, 0);
        tbl[3]  = mk(1, 0, 1, 1, 36'h4, 3'd0, 1, 4'd0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 36'h4, 3'd0, 1, 4'd1, 0);
        tbl[5]  = mk(1, 0, 0, 0, 36'h4, 3'd0, 1, 4'd2, 0);
        tbl[6]  = mk(1, 1, 0, 0, 36'h4, 3'd1, 0, 4'd3, 0);
        tbl[7]  = mk(1, 0, 1, 1, 36'h5, 3'd0, 1, 4'd3, 0);
        tbl[8]  = mk(1, 1, 0, 0, 36'h5, 3'd1, 0, 4'd4, 0);
        tbl[9]  = mk(1, 1, 1, 1, 36'h6, 3'd1, 0, 4'd4, 0);
        tbl[10] = mk(1, 0, 0, 0, 36'h6, 3'd1, 0, 4'd4, 0);
        tbl[11] = mk(1, 1, 0, 0, 36'h6, 3'd2, 0, 4'd4, 0);
        tbl[12] = mk(1, 1, 0, 0, 36'h6, 3'd3, 0, 4'd4, 0);
        tbl[13] = mk(1, 1, 0, 0, 36'h6, 3'd4, 0, 4'd4, 0);
        tbl[14] = mk(1, 1, 0, 0, 36'h6, 3'd4, 0, 4'd4, 1);
        tbl[15] = mk(1, 0, 0, 0, 36'h6, 3'd4, 0, 4'd4, 1);

        for (int k = 1; k <= 6; k++) push(W'(k));
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].en, tbl[i].cin, tbl[i].exp_read);
            chk_regs($sformatf("row%0d", i), tbl[i].exp_valid, tbl[i].exp_data, tbl[i].exp_cred,
                     tbl[i].exp_stalled, tbl[i].exp_scnt, tbl[i].exp_err);
        end

        // Reset asserted during the second send of a three-entry stream
        push(36'hA); push(36'hB); push(36'hC);
        step(1, 0, 1);
        chk_regs("mid.first", 1'b1, 36'hA, 3'd3, 1'b0, 4'd4, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk_regs("mid.async", 1'b0, '0, 3'd4, 1'b0, 4'd0, 1'b0);
        @(posedge clock);
        #1;
        chk_regs("mid.next", 1'b0, '0, 3'd4, 1'b0, 4'd0, 1'b0);
        do_reset();

        // Enable low freezes everything, credit_in ignored meanwhile
        for (int k = 0; k < 4; k++) push(W'(36'h10 + k));
        step(1, 0, 1);
        chk_regs("en.pre", 1'b1, 36'h10, 3'd3, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(0, (i == 2), 0);
            chk_regs($sformatf("en.frz%0d", i), 1'b1, 36'h10, 3'd3, 1'b0, 4'd0, 1'b0);
        end
        step(1, 0, 1);
        chk_regs("en.res0", 1'b1, 36'h11, 3'd2, 1'b0, 4'd0, 1'b0);
        step(1, 0, 1);
        chk_regs("en.res1", 1'b1, 36'h12, 3'd1, 1'b0, 4'd0, 1'b0);
        do_reset();

        // Stall counter saturation at 15
        for (int k = 0; k < 6; k++) push(W'(36'h21 + k));
        for (int i = 0; i < 4; i++) step(1, 0, 1);
        chk_regs("sat.start", 1'b1, 36'h24, 3'd0, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        chk_regs("sat.ten", 1'b0, 36'h24, 3'd0, 1'b1, 4'd10, 1'b0);
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        chk_regs("sat.twenty", 1'b0, 36'h24, 3'd0, 1'b1, 4'd15, 1'b0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        chk("sat.hold.stall_count", 64'(stall_count), 64'(4'd15));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
